// File: rtl/neighbor_bank_cntl_if.sv
// Request, SRAM and response signals between the neighbor memory controller, one SRAM bank and the PEs.
// The slave modport is the bank controller's view; the master modport is everything around it.
interface neighbor_bank_cntl_if #(
  parameter int BANK_ADDR_W = 2,
  parameter int PE_TAG_W    = 2,
  parameter int DATA_W      = 32,
  parameter int BURST_LEN   = 4
);
  localparam int MEM_ADDR_W = BANK_ADDR_W + $clog2(BURST_LEN);

  logic                   req_valid;
  logic [PE_TAG_W-1:0]    req_pe_tag;
  logic [BANK_ADDR_W-1:0] req_bank_addr;
  logic                   bank_busy;
  logic                   req_drop;
  logic                   mem_cen;
  logic [MEM_ADDR_W-1:0]  mem_addr;
  logic [DATA_W-1:0]      mem_rdata;
  logic                   rsp_valid;
  logic                   rsp_ready;
  logic [PE_TAG_W-1:0]    rsp_pe_tag;
  logic [DATA_W-1:0]      rsp_data;
  logic                   rsp_last;

  modport slave (
    input  req_valid, req_pe_tag, req_bank_addr, mem_rdata, rsp_ready,
    output bank_busy, req_drop, mem_cen, mem_addr, rsp_valid, rsp_pe_tag, rsp_data, rsp_last
  );

  modport master (
    output req_valid, req_pe_tag, req_bank_addr, mem_rdata, rsp_ready,
    input  bank_busy, req_drop, mem_cen, mem_addr, rsp_valid, rsp_pe_tag, rsp_data, rsp_last
  );
endinterface

// File: rtl/neighbor_bank_cntl.sv
// Reads a BURST_LEN-word neighbor entry per request; first beat valid 3 cycles after the request, >=3 cycles/beat.
// rsp_ready low parks the beat in HOLD without re-reading; requests arriving while busy are dropped.
module neighbor_bank_cntl #(
  parameter int BANK_ADDR_W = 2,
  parameter int PE_TAG_W    = 2,
  parameter int DATA_W      = 32,
  parameter int BURST_LEN   = 4
) (
  input logic                clk,
  input logic                reset,
  neighbor_bank_cntl_if.slave bus
);
  localparam int BEAT_W = $clog2(BURST_LEN);
  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BURST_LEN - 1);

  typedef enum logic [1:0] {IDLE, ISSUE, CAPTURE, HOLD} state_e;

  state_e                 state_q, state_d;
  logic [BEAT_W-1:0]      beat_q, beat_d;
  logic [PE_TAG_W-1:0]    tag_q, tag_d;
  logic [BANK_ADDR_W-1:0] base_q, base_d;
  logic [DATA_W-1:0]      data_q, data_d;

  always_comb begin
    state_d = state_q;
    beat_d  = beat_q;
    tag_d   = tag_q;
    base_d  = base_q;
    data_d  = data_q;
    case (state_q)
      IDLE: begin
        if (bus.req_valid) begin
          tag_d   = bus.req_pe_tag;
          base_d  = bus.req_bank_addr;
          beat_d  = '0;
          state_d = ISSUE;
        end
      end
      ISSUE: state_d = CAPTURE;
      CAPTURE: begin
        data_d  = bus.mem_rdata;
        state_d = HOLD;
      end
      HOLD: begin
        // The word stays parked here until taken, so stalls never cost a second SRAM read.
        if (bus.rsp_ready) begin
          if (beat_q == LAST_BEAT) begin
            state_d = IDLE;
          end else begin
            beat_d  = beat_q + 1'b1;
            state_d = ISSUE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      beat_q  <= '0;
      tag_q   <= '0;
      base_q  <= '0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      beat_q  <= beat_d;
      tag_q   <= tag_d;
      base_q  <= base_d;
      data_q  <= data_d;
    end
  end

  assign bus.bank_busy  = (state_q != IDLE);
  assign bus.req_drop   = bus.req_valid && (state_q != IDLE);
  assign bus.mem_cen    = (state_q != ISSUE);
  assign bus.mem_addr   = (state_q == ISSUE) ? {base_q, beat_q} : '0;
  assign bus.rsp_valid  = (state_q == HOLD);
  assign bus.rsp_last   = (state_q == HOLD) && (beat_q == LAST_BEAT);
  assign bus.rsp_pe_tag = tag_q;
  assign bus.rsp_data   = data_q;
endmodule

// File: tb/tb_neighbor_bank_cntl.sv
// Directed scenarios followed by random traffic, checked cycle by cycle against a timing-level model.
module tb_neighbor_bank_cntl;
  localparam int BANK_ADDR_W = 2;
  localparam int PE_TAG_W    = 2;
  localparam int DATA_W      = 32;
  localparam int BURST_LEN   = 4;
  localparam int MEM_WORDS   = (1 << BANK_ADDR_W) * BURST_LEN;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  neighbor_bank_cntl_if #(
    .BANK_ADDR_W(BANK_ADDR_W), .PE_TAG_W(PE_TAG_W), .DATA_W(DATA_W), .BURST_LEN(BURST_LEN)
  ) bus ();

  neighbor_bank_cntl #(
    .BANK_ADDR_W(BANK_ADDR_W), .PE_TAG_W(PE_TAG_W), .DATA_W(DATA_W), .BURST_LEN(BURST_LEN)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  // SRAM model: one-cycle read latency, counts every access.
  logic [DATA_W-1:0] mem_arr [MEM_WORDS];
  int reads = 0;
  always @(posedge clk) begin
    if (bus.mem_cen === 1'b0) begin
      bus.mem_rdata <= mem_arr[bus.mem_addr];
      reads <= reads + 1;
    end
  end

  int total = 0;
  int bad   = 0;

  // Reference model: a burst is either absent or at some beat, some cycles after that beat began.
  bit m_busy  = 1'b0;
  bit armed   = 1'b0;
  int m_base  = 0;
  int m_tag   = 0;
  int m_beat  = 0;
  int m_t     = 0;
  int exp_reads = 0;
  int beats_done = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input bit rv, input int a, input int tg, input bit rr, input bit rst);
    int idx;
    bit issuing, holding;
    @(negedge clk);
    reset             = rst;
    bus.req_valid     = rv;
    bus.req_bank_addr = a[BANK_ADDR_W-1:0];
    bus.req_pe_tag    = tg[PE_TAG_W-1:0];
    bus.rsp_ready     = rr;
    #1;
    idx     = m_base * BURST_LEN + m_beat;
    issuing = m_busy && (m_t == 0);
    holding = m_busy && (m_t >= 2);
    if (armed) begin
      chk("bank_busy", 32'(bus.bank_busy), 32'(m_busy));
      chk("req_drop",  32'(bus.req_drop),  32'(rv && m_busy));
      chk("mem_cen",   32'(bus.mem_cen),   32'(!issuing));
      chk("mem_addr",  32'(bus.mem_addr),  issuing ? 32'(idx) : 32'd0);
      chk("rsp_valid", 32'(bus.rsp_valid), 32'(holding));
      chk("rsp_last",  32'(bus.rsp_last),  32'(holding && (m_beat == BURST_LEN - 1)));
      if (holding) begin
        chk("rsp_data",   bus.rsp_data,          mem_arr[idx]);
        chk("rsp_pe_tag", 32'(bus.rsp_pe_tag),   32'(m_tag));
      end
    end
    if (issuing) exp_reads++;
    if (rst) begin
      m_busy = 1'b0;
      armed  = 1'b1;
    end else if (!m_busy) begin
      if (rv) begin
        m_busy = 1'b1;
        m_base = a;
        m_tag  = tg;
        m_beat = 0;
        m_t    = 0;
      end
    end else if (holding) begin
      if (rr) begin
        beats_done++;
        if (m_beat == BURST_LEN - 1) m_busy = 1'b0;
        else begin
          m_beat++;
          m_t = 0;
        end
      end
    end else begin
      m_t++;
    end
  endtask

  initial begin
    for (int i = 0; i < MEM_WORDS; i++) mem_arr[i] = 32'h100 + i;
    reset = 1'b1;
    bus.req_valid = 1'b0;
    bus.req_bank_addr = '0;
    bus.req_pe_tag = '0;
    bus.rsp_ready = 1'b1;

    // Reset, then reset values
    cyc(0, 0, 0, 1, 1);
    cyc(0, 0, 0, 1, 1);
    cyc(0, 0, 0, 1, 0);
    chk("rst_rsp_data", bus.rsp_data, 32'd0);
    chk("rst_rsp_tag", 32'(bus.rsp_pe_tag), 32'd0);

    // Base burst: addr 2, tag 1
    cyc(1, 2, 1, 1, 0);
    for (int i = 1; i <= 12; i++) cyc(0, 0, 0, 1, 0);
    cyc(0, 0, 0, 1, 0);

    // Backpressure on beat 1 for five cycles
    cyc(1, 2, 1, 1, 0);
    for (int i = 1; i <= 20; i++) cyc(0, 0, 0, !(i >= 6 && i <= 10), 0);

    // Request while busy is dropped
    cyc(1, 2, 1, 1, 0);
    for (int i = 1; i <= 14; i++) cyc(i == 5, 0, 0, 1, 0);

    // Back-to-back: second request in the first idle cycle
    cyc(1, 2, 1, 1, 0);
    for (int i = 1; i <= 26; i++) cyc(i == 13, 1, 2, 1, 0);

    // Reset while holding beat 2, then a fresh burst from addr 0
    cyc(1, 2, 1, 1, 0);
    for (int i = 1; i <= 8; i++) cyc(0, 0, 0, 1, 0);
    cyc(0, 0, 0, 1, 1);
    cyc(0, 0, 0, 1, 0);
    cyc(1, 0, 0, 1, 0);
    for (int i = 1; i <= 13; i++) cyc(0, 0, 0, 1, 0);

    // Highest entry
    cyc(1, 3, 3, 1, 0);
    for (int i = 1; i <= 13; i++) cyc(0, 0, 0, 1, 0);
    chk("reads_directed", 32'(reads), 32'(exp_reads));

    // Random traffic over random memory contents
    for (int i = 0; i < MEM_WORDS; i++) mem_arr[i] = $urandom;
    for (int i = 0; i < 1500; i++) begin
      cyc($urandom_range(0, 3) == 0, $urandom_range(0, 3), $urandom_range(0, 3),
          $urandom_range(0, 9) < 7, $urandom_range(0, 99) == 0);
    end
    for (int i = 0; i < 20; i++) cyc(0, 0, 0, 1, 0);
    chk("reads_total", 32'(reads), 32'(exp_reads));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
